// File: rtl/dispatch_unit.sv
// dispatch_unit: in-order dispatch stage with register renaming.
// Holds the architectural register file, a register status table (busy bit
// plus the tag of the in-flight producer) and a free-tag FIFO. Each cycle it
// resolves the source operands of the instruction at the head of the issue
// queue, allocates a tag for its destination and hands everything to one of
// four back-end queues. The result bus (CDB) retires tags back into the FIFO
// and writes results into the register file.
module dispatch_unit (
    input  logic        clk,
    input  logic        rst,

    // Decoded instruction from the issue queue
    input  logic        iq_valid,
    output logic        iq_ready,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic        rd_write,
    input  logic        rs2_use,
    input  logic [31:0] imm,
    input  logic [2:0]  funct3,
    input  logic [1:0]  unit_sel,
    input  logic [2:0]  alu_ext,
    input  logic        agu_ls,

    // Back-end queue write port (shared payload, one enable per unit)
    output logic [31:0] queue_op1_data,
    output logic [5:0]  queue_op1_tag,
    output logic        queue_op1_data_valid,
    output logic [31:0] queue_op2_data,
    output logic [5:0]  queue_op2_tag,
    output logic        queue_op2_data_valid,
    output logic [5:0]  queue_rd_tag,
    output logic        queue_rd_tag_valid,
    output logic [2:0]  queue_funct3,
    output logic        queue_alu_en,
    output logic        queue_agu_en,
    output logic        queue_mul_en,
    output logic        queue_div_en,
    output logic [2:0]  queue_alu_ext,
    output logic        queue_agu_ls,
    output logic [31:0] queue_agu_imm,

    // Back-pressure from the back-end queues
    input  logic        queue_alu_full,
    input  logic        queue_agu_full,
    input  logic        queue_mul_full,
    input  logic        queue_div_full,

    // Common data bus snoop
    input  logic        cdb_valid,
    input  logic [5:0]  cdb_tag,
    input  logic [31:0] cdb_data
);

    typedef enum logic [1:0] {
        UNIT_ALU = 2'd0,
        UNIT_AGU = 2'd1,
        UNIT_MUL = 2'd2,
        UNIT_DIV = 2'd3
    } unit_e;

    typedef struct packed {
        logic [31:0] data;
        logic [5:0]  tag;
        logic        valid;
    } operand_t;

    localparam logic [6:0] TAG_COUNT = 7'd64;

    // Architectural state
    logic [31:0] regfile_q [32];
    logic [31:0] regfile_d [32];
    logic [31:0] busy_q;
    logic [31:0] busy_d;
    logic [5:0]  tag_q [32];
    logic [5:0]  tag_d [32];

    // Free-tag FIFO
    logic [5:0]  fifo_q [64];
    logic [5:0]  fifo_d [64];
    logic [5:0]  head_q, head_d;
    logic [5:0]  tail_q, tail_d;
    logic [6:0]  count_q, count_d;

    // Front-end decisions
    unit_e       unit;
    logic        needs_tag;
    logic        unit_full;
    logic        dispatch_fire;
    logic        tag_pop;
    logic        tag_push;
    operand_t    op1;
    operand_t    op2;

    // Source resolution: r0 is hard zero, a producer broadcasting this cycle
    // forwards its result, an outstanding producer yields its tag, otherwise
    // the register file holds the committed value.
    function automatic operand_t resolve_src(
        input logic [4:0]  rs,
        input logic        busy,
        input logic [5:0]  tag,
        input logic [31:0] rf_data,
        input logic        bus_valid,
        input logic [5:0]  bus_tag,
        input logic [31:0] bus_data
    );
        operand_t res;
        if (rs == 5'd0) begin
            res = '{data: 32'd0, tag: 6'd0, valid: 1'b1};
        end else if (busy && bus_valid && (bus_tag == tag)) begin
            res = '{data: bus_data, tag: 6'd0, valid: 1'b1};
        end else if (busy) begin
            res = '{data: 32'd0, tag: tag, valid: 1'b0};
        end else begin
            res = '{data: rf_data, tag: 6'd0, valid: 1'b1};
        end
        return res;
    endfunction

    assign unit      = unit_e'(unit_sel);
    assign needs_tag = rd_write && (rd != 5'd0);

    // Handshake and dispatch qualification
    always_comb begin
        // NOTE: every signal driven here gets a value before any branch, so no latch can be inferred.
        unit_full = 1'b0;
        case (unit)
            UNIT_ALU: unit_full = queue_alu_full;
            UNIT_AGU: unit_full = queue_agu_full;
            UNIT_MUL: unit_full = queue_mul_full;
            UNIT_DIV: unit_full = queue_div_full;
            default:  unit_full = 1'b1;
        endcase
        iq_ready      = !unit_full && (!needs_tag || (count_q != 7'd0));
        dispatch_fire = iq_valid && iq_ready && !rst;
        tag_pop       = dispatch_fire && needs_tag;
        // The CDB only returns allocated tags, so a push on a full FIFO is a
        // protocol error and is simply dropped.
        tag_push      = cdb_valid && (count_q != TAG_COUNT);
    end

    // Operand selection, using the status table as it stood before this
    // cycle's own destination update (rs == rd sees the old mapping).
    always_comb begin
        op1 = resolve_src(rs1, busy_q[rs1], tag_q[rs1], regfile_q[rs1],
                          cdb_valid, cdb_tag, cdb_data);
        if ((unit == UNIT_ALU) && !rs2_use) begin
            op2 = '{data: imm, tag: 6'd0, valid: 1'b1};
        end else begin
            // AGU always reads rs2 as store data; its immediate travels separately.
            op2 = resolve_src(rs2, busy_q[rs2], tag_q[rs2], regfile_q[rs2],
                              cdb_valid, cdb_tag, cdb_data);
        end
    end

    assign queue_op1_data       = op1.data;
    assign queue_op1_tag        = op1.tag;
    assign queue_op1_data_valid = op1.valid;
    assign queue_op2_data       = op2.data;
    assign queue_op2_tag        = op2.tag;
    assign queue_op2_data_valid = op2.valid;

    assign queue_rd_tag         = fifo_q[head_q];
    assign queue_rd_tag_valid   = needs_tag;

    assign queue_alu_en         = dispatch_fire && (unit == UNIT_ALU);
    assign queue_agu_en         = dispatch_fire && (unit == UNIT_AGU);
    assign queue_mul_en         = dispatch_fire && (unit == UNIT_MUL);
    assign queue_div_en         = dispatch_fire && (unit == UNIT_DIV);

    assign queue_funct3         = funct3;
    assign queue_alu_ext        = alu_ext;
    assign queue_agu_ls         = agu_ls;
    assign queue_agu_imm        = imm;

    // Next state of register file, status table and tag FIFO
    always_comb begin
        regfile_d = regfile_q;
        busy_d    = busy_q;
        tag_d     = tag_q;
        fifo_d    = fifo_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;

        // Result bus: commit to every register still waiting on this tag.
        if (cdb_valid) begin
            for (int r = 0; r < 32; r++) begin
                if (busy_q[r] && (tag_q[r] == cdb_tag)) begin
                    regfile_d[r] = cdb_data;
                    busy_d[r]    = 1'b0;
                end
            end
        end

        // A new mapping for rd overrides a same-cycle clear of that rd; the
        // register file still takes the broadcast value above.
        if (tag_pop) begin
            busy_d[rd] = 1'b1;
            tag_d[rd]  = fifo_q[head_q];
            head_d     = head_q + 6'd1;
        end

        if (tag_push) begin
            fifo_d[tail_q] = cdb_tag;
            tail_d         = tail_q + 6'd1;
        end

        case ({tag_push, tag_pop})
            2'b10:   count_d = count_q + 7'd1;
            2'b01:   count_d = count_q - 7'd1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards all in-flight tags and refills the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: these arrays are architectural state that software expects zeroed and the FIFO must start full, so they are reset rather than left as uninitialised RAM.
            for (int r = 0; r < 32; r++) begin
                regfile_q[r] <= 32'd0;
                tag_q[r]     <= 6'd0;
            end
            for (int i = 0; i < 64; i++) begin
                fifo_q[i] <= 6'(i);
            end
            busy_q  <= 32'd0;
            head_q  <= 6'd0;
            tail_q  <= 6'd0;
            count_q <= TAG_COUNT;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge value of its neighbours.
            regfile_q <= regfile_d;
            busy_q    <= busy_d;
            tag_q     <= tag_d;
            fifo_q    <= fifo_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_dispatch_unit.sv
// tb_dispatch_unit: scoreboard bench for dispatch_unit. A stimulus process
// drives one instruction per cycle and predicts the response from a
// behavioural model (architectural registers, rename map, free-tag queue);
// a monitor pops predictions whenever the DUT raises a queue enable.
module tb_dispatch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iq_valid, iq_ready;
    logic [4:0]  rs1, rs2, rd;
    logic        rd_write, rs2_use;
    logic [31:0] imm;
    logic [2:0]  funct3;
    logic [1:0]  unit_sel;
    logic [2:0]  alu_ext;
    logic        agu_ls;
    logic [31:0] queue_op1_data, queue_op2_data, queue_agu_imm;
    logic [5:0]  queue_op1_tag, queue_op2_tag, queue_rd_tag;
    logic        queue_op1_data_valid, queue_op2_data_valid, queue_rd_tag_valid;
    logic [2:0]  queue_funct3, queue_alu_ext;
    logic        queue_alu_en, queue_agu_en, queue_mul_en, queue_div_en;
    logic        queue_agu_ls;
    logic        queue_alu_full, queue_agu_full, queue_mul_full, queue_div_full;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;

    always #5 clk = ~clk;

    dispatch_unit dut (
        .clk(clk), .rst(rst),
        .iq_valid(iq_valid), .iq_ready(iq_ready),
        .rs1(rs1), .rs2(rs2), .rd(rd), .rd_write(rd_write), .rs2_use(rs2_use),
        .imm(imm), .funct3(funct3), .unit_sel(unit_sel), .alu_ext(alu_ext), .agu_ls(agu_ls),
        .queue_op1_data(queue_op1_data), .queue_op1_tag(queue_op1_tag),
        .queue_op1_data_valid(queue_op1_data_valid),
        .queue_op2_data(queue_op2_data), .queue_op2_tag(queue_op2_tag),
        .queue_op2_data_valid(queue_op2_data_valid),
        .queue_rd_tag(queue_rd_tag), .queue_rd_tag_valid(queue_rd_tag_valid),
        .queue_funct3(queue_funct3),
        .queue_alu_en(queue_alu_en), .queue_agu_en(queue_agu_en),
        .queue_mul_en(queue_mul_en), .queue_div_en(queue_div_en),
        .queue_alu_ext(queue_alu_ext), .queue_agu_ls(queue_agu_ls), .queue_agu_imm(queue_agu_imm),
        .queue_alu_full(queue_alu_full), .queue_agu_full(queue_agu_full),
        .queue_mul_full(queue_mul_full), .queue_div_full(queue_div_full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data)
    );

    typedef struct {
        logic        v;
        logic [4:0]  rs1, rs2, rd;
        logic        rdw, rs2u;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic [1:0]  us;
        logic [2:0]  ext;
        logic        ls;
        logic [3:0]  full;   // {div, mul, agu, alu}
        logic        cv;
        logic [5:0]  ct;
        logic [31:0] cd;
    } stim_t;

    typedef struct {
        logic [1:0]  unit;
        logic [31:0] op1_data, op2_data, agu_imm;
        logic [5:0]  op1_tag, op2_tag, rd_tag;
        logic        op1_valid, op2_valid, rd_tag_valid;
        logic [2:0]  funct3, alu_ext;
        logic        agu_ls;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;

    // Behavioural model: committed values, rename map, free tags in order.
    logic [31:0] m_regs [32];
    logic        m_busy [32];
    logic [5:0]  m_tag  [32];
    logic [5:0]  free_q[$];
    logic [5:0]  inflight[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = 32'd0;
            m_busy[r] = 1'b0;
            m_tag[r]  = 6'd0;
        end
        free_q.delete();
        for (int i = 0; i < 64; i++) free_q.push_back(6'(i));
        inflight.delete();
    endfunction

    function automatic void resolve(input logic [4:0] rs, input stim_t s,
                                    output logic [31:0] d, output logic [5:0] t, output logic v);
        if (rs == 5'd0) begin
            d = 32'd0; t = 6'd0; v = 1'b1;
        end else if (m_busy[rs] && s.cv && s.ct == m_tag[rs]) begin
            d = s.cd; t = 6'd0; v = 1'b1;
        end else if (m_busy[rs]) begin
            d = 32'd0; t = m_tag[rs]; v = 1'b0;
        end else begin
            d = m_regs[rs]; t = 6'd0; v = 1'b1;
        end
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{v: 1'b0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, rdw: 1'b0, rs2u: 1'b0, imm: 32'd0,
              f3: 3'd0, us: 2'd0, ext: 3'd0, ls: 1'b0, full: 4'd0, cv: 1'b0, ct: 6'd0, cd: 32'd0};
        return s;
    endfunction

    // One clock cycle: drive at posedge+1, predict, check ready at negedge,
    // advance the model at the next posedge.
    task automatic step(input stim_t s);
        logic nt, exp_ready, disp, push_ok;
        logic [5:0] t;
        exp_t e;
        iq_valid = s.v; rs1 = s.rs1; rs2 = s.rs2; rd = s.rd; rd_write = s.rdw;
        rs2_use = s.rs2u; imm = s.imm; funct3 = s.f3; unit_sel = s.us;
        alu_ext = s.ext; agu_ls = s.ls;
        {queue_div_full, queue_mul_full, queue_agu_full, queue_alu_full} = s.full;
        cdb_valid = s.cv; cdb_tag = s.ct; cdb_data = s.cd;

        nt        = s.rdw && (s.rd != 5'd0);
        exp_ready = !s.full[s.us] && (!nt || free_q.size() != 0);
        disp      = s.v && exp_ready;
        t         = 6'd0;
        if (disp) begin
            e.unit = s.us;
            resolve(s.rs1, s, e.op1_data, e.op1_tag, e.op1_valid);
            if (s.us == 2'd0 && !s.rs2u) begin
                e.op2_data = s.imm; e.op2_tag = 6'd0; e.op2_valid = 1'b1;
            end else begin
                resolve(s.rs2, s, e.op2_data, e.op2_tag, e.op2_valid);
            end
            e.rd_tag_valid = nt;
            e.rd_tag       = nt ? free_q[0] : 6'd0;
            e.funct3 = s.f3; e.alu_ext = s.ext; e.agu_ls = s.ls; e.agu_imm = s.imm;
            exp_q.push_back(e);
        end

        @(negedge clk);
        check("iq_ready", iq_ready, exp_ready);
        @(posedge clk);

        push_ok = s.cv && (free_q.size() < 64);
        if (disp && nt) begin
            t = free_q.pop_front();
            inflight.push_back(t);
        end
        if (s.cv) begin
            for (int r = 0; r < 32; r++) begin
                if (m_busy[r] && m_tag[r] == s.ct) begin
                    m_regs[r] = s.cd;
                    m_busy[r] = 1'b0;
                end
            end
            for (int i = 0; i < inflight.size(); i++) begin
                if (inflight[i] == s.ct) begin
                    inflight.delete(i);
                    break;
                end
            end
        end
        if (push_ok) free_q.push_back(s.ct);
        if (disp && nt) begin
            m_busy[s.rd] = 1'b1;
            m_tag[s.rd]  = t;
        end
        #1;
    endtask

    // Reset with a live instruction and CDB traffic: nothing may dispatch.
    task automatic do_reset();
        rst = 1'b1;
        iq_valid = 1'b1; rd_write = 1'b1; rd = 5'd5; rs1 = 5'd0; rs2 = 5'd0;
        rs2_use = 1'b0; unit_sel = 2'd0; imm = 32'd0; funct3 = 3'd0;
        alu_ext = 3'd0; agu_ls = 1'b0;
        {queue_div_full, queue_mul_full, queue_agu_full, queue_alu_full} = 4'd0;
        cdb_valid = 1'b1; cdb_tag = 6'($urandom); cdb_data = $urandom;
        @(negedge clk);
        check("reset_en", {queue_div_en, queue_mul_en, queue_agu_en, queue_alu_en}, 4'd0);
        @(posedge clk);
        #2;
        iq_valid = 1'b0; cdb_valid = 1'b0;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented dispatch must match the oldest prediction.
    exp_t       mon_e;
    logic [3:0] mon_en;
    always @(negedge clk) begin
        if (!rst) begin
            mon_en = {queue_div_en, queue_mul_en, queue_agu_en, queue_alu_en};
            if (mon_en != 4'd0 && exp_q.size() == 0) begin
                check("unexpected_dispatch", 32'(mon_en), 32'd0);
            end else if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("unit_en",    32'(mon_en), 32'(4'b0001 << mon_e.unit));
                check("op1_data",   queue_op1_data, mon_e.op1_data);
                check("op1_tag",    32'(queue_op1_tag), 32'(mon_e.op1_tag));
                check("op1_valid",  32'(queue_op1_data_valid), 32'(mon_e.op1_valid));
                check("op2_data",   queue_op2_data, mon_e.op2_data);
                check("op2_tag",    32'(queue_op2_tag), 32'(mon_e.op2_tag));
                check("op2_valid",  32'(queue_op2_data_valid), 32'(mon_e.op2_valid));
                check("rd_tag_valid", 32'(queue_rd_tag_valid), 32'(mon_e.rd_tag_valid));
                if (mon_e.rd_tag_valid) check("rd_tag", 32'(queue_rd_tag), 32'(mon_e.rd_tag));
                check("funct3",     32'(queue_funct3), 32'(mon_e.funct3));
                check("alu_ext",    32'(queue_alu_ext), 32'(mon_e.alu_ext));
                check("agu_ls",     32'(queue_agu_ls), 32'(mon_e.agu_ls));
                check("agu_imm",    queue_agu_imm, mon_e.agu_imm);
            end
        end
    end

    initial begin
        stim_t s;
        int    idx;
        model_reset();
        do_reset();

        // Immediate ALU op to r5, then a dependent read, then a forwarded read.
        s = idle(); s.v = 1; s.rd = 5; s.rdw = 1; s.imm = 32'd7; s.us = 2'd0;
        step(s);
        s = idle(); s.v = 1; s.rs1 = 5; s.rd = 6; s.rdw = 1; s.rs2u = 1; s.rs2 = 0;
        step(s);
        s.cv = 1; s.ct = 6'd0; s.cd = 32'h1234; s.rd = 7;
        step(s);

        // MUL held against a full MUL queue, then released.
        s = idle(); s.v = 1; s.us = 2'd2; s.rs1 = 6; s.rs2 = 5; s.rs2u = 1; s.rd = 8; s.rdw = 1;
        s.full = 4'b0100;
        for (int i = 0; i < 3; i++) step(s);
        s.full = 4'b0000;
        step(s);

        // Exhaust the tag pool, stall, store still goes, one return unblocks.
        do_reset();
        for (int i = 0; i < 64; i++) begin
            s = idle(); s.v = 1; s.rd = 5'(1 + i % 31); s.rdw = 1; s.imm = 32'(i);
            step(s);
        end
        s = idle(); s.v = 1; s.rd = 9; s.rdw = 1; s.us = 2'd0; s.imm = 32'h99;
        step(s);
        s = idle(); s.v = 1; s.us = 2'd1; s.rs1 = 1; s.rs2 = 2; s.rdw = 0; s.ls = 1; s.imm = 32'h40;
        step(s);
        s = idle(); s.v = 1; s.rd = 9; s.rdw = 1; s.imm = 32'h99;
        s.cv = 1; s.ct = 6'd17; s.cd = 32'hCAFE;
        step(s);
        s.cv = 0;
        step(s);

        // Dispatch to r3 in the same cycle the CDB clears r3.
        do_reset();
        s = idle(); s.v = 1; s.rd = 3; s.rdw = 1;
        step(s);
        s.cv = 1; s.ct = 6'd0; s.cd = 32'hABCD;
        step(s);
        s = idle(); s.v = 1; s.rs1 = 3; s.rs2 = 3; s.rs2u = 1; s.us = 2'd3;
        step(s);
        s = idle(); s.cv = 1; s.ct = 6'd1; s.cd = 32'h55;
        step(s);
        s = idle(); s.v = 1; s.rs1 = 3; s.us = 2'd2; s.rs2u = 1; s.rs2 = 0;
        step(s);

        // Randomized traffic with a reset in the middle.
        for (int n = 0; n < 1500; n++) begin
            if (n == 700) do_reset();
            s.v    = ($urandom % 4) != 0;
            s.rs1  = 5'($urandom % 8);
            s.rs2  = 5'($urandom % 8);
            s.rd   = 5'($urandom % 8);
            s.rdw  = ($urandom % 4) != 0;
            s.rs2u = 1'($urandom);
            s.imm  = $urandom;
            s.f3   = 3'($urandom);
            s.us   = 2'($urandom);
            s.ext  = 3'($urandom);
            s.ls   = 1'($urandom);
            for (int b = 0; b < 4; b++) s.full[b] = ($urandom % 8) == 0;
            s.cv = 1'b0; s.ct = 6'd0; s.cd = $urandom;
            if (inflight.size() != 0 && ($urandom % 2) == 1) begin
                idx  = $urandom_range(0, inflight.size() - 1);
                s.cv = 1'b1;
                s.ct = inflight[idx];
            end
            step(s);
        end

        s = idle();
        step(s);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
